twiddle_seq: RTL and testbench
==============================

Name: twiddle_seq

Overview:
- Read-side sequencer for the 16-entry twiddle constant ROM (4-bit address, 1-cycle registered read, 32-bit {re,im} word).
- Per start pulse, walks all 5 radix-2 stages of a 32-point FFT, 16 butterflies per stage, and issues the matching ROM addresses.
- Captures the ROM data and streams it to the PE array over a valid/ready interface with full throughput and backpressure.
- Sits between the FFT control FSM and the PE twiddle input.

Parameters:
- DATA_WIDTH, 16 (from parameters.vh): real/imag component width; twiddle word is DATA_WIDTH*2.
- NUM_FRAMES, 1: frames sequenced per start pulse (1..255).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle request to begin NUM_FRAMES frames.
- busy  out  1  high from the cycle after an accepted start until the last word is accepted.
- done  out  1  one-cycle pulse the cycle after the final tw_valid&&tw_ready.
- rom_en  out  1  ROM read enable.
- rom_addr  out  4  ROM address.
- rom_data  in  DATA_WIDTH*2  ROM output; valid the cycle after rom_en.
- tw_data  out  DATA_WIDTH*2  twiddle word to the PE.
- tw_stage  out  3  stage index 0..4 of tw_data.
- tw_idx  out  4  butterfly index j 0..15 of tw_data.
- tw_last  out  1  set on the final word of each frame (stage 4, j=15).
- tw_valid  out  1  output valid.
- tw_ready  in  1  PE ready.

Behaviour:
- Reset values: busy=0, done=0, rom_en=0, rom_addr=0, tw_valid=0, tw_data=0, tw_stage=0, tw_idx=0, tw_last=0.
- Reset clears all counters, the in-flight flag and the buffer, from any state.
- FSM states:
  - IDLE: start → RUN; frame, stage and j counters cleared.
  - RUN: issues reads; after the last issue of the last frame → DRAIN.
  - DRAIN: waits for the buffer to empty → IDLE with done pulsed.
- start is ignored unless in IDLE.
- Address (DIT): rom_addr = (j & ((1<<s)-1)) << (4-s), for s=stage and j=butterfly.
- Counter order: j increments fastest, then s, then frame. j wraps 15→0 and s increments. s wraps 4→0 and frame increments.
- rom_en is asserted only when issuing a read. Tag {s, j, last} is pipelined one cycle alongside the read.
- Output buffer: 2-entry skid FIFO; head drives tw_*.
- Issue rule: issue when occupancy + inflight − pop < 2, where pop = tw_valid && tw_ready.
- Sustained throughput is 1 word/clk while tw_ready=1.
- First tw_valid appears 2 cycles after start is accepted.
- tw_data and tags stay stable while tw_valid && !tw_ready.
- Simultaneous push (ROM return) and pop: occupancy unchanged, order preserved.
- A full buffer stalls issue; no word is ever dropped or duplicated.
- done does not wait on anything other than the final handshake.

Optional Feature:
- Macro: TWIDDLE_SEQ_DIF_EN.
- Defined: decimation-in-frequency ordering, rom_addr = (j & ((1<<(4-s))-1)) << s; stage 0 sweeps 0..15 and stage 4 is all zeros.
- Undefined: DIT formula above.
- Ports and timing are identical in both cases.

Decomposition:
- Shared package/header: TW_ADDR_W=4, TW_STAGES=5, TW_PER_STAGE=16, FSM state encodings, DIT/DIF address function.
- One sub-module, twiddle_skid_fifo: 2-entry valid/ready buffer, width DATA_WIDTH*2+8.
- The ROM is instantiated outside this block.

Test Plan:
- tw_ready=1, start, bound to the real ROM → 80 words in 80 consecutive cycles after 2-cycle latency.
  - Stage 0: all 32'h0001_0000.
  - Stage 1: j even → 32'h0001_0000; j odd → addr 8, 32'h0000_0001.
  - Stage 4, j=3: 32'hD4DB_8E40; tw_last only on word 80.
  - done pulses once, busy falls the same cycle.
- tw_ready toggling 1/0 each cycle → same 80-word sequence with no loss or duplication; tw_data stable during stall cycles.
- tw_ready=0 for 10 cycles mid-stage 2 → rom_en stops after the buffer fills (≤2 words + 1 in flight), then resumes the exact sequence.
- start re-pulsed while busy → ignored; exactly 80 words and one done.
- rst asserted during stage 3 → next cycle all outputs at reset values; a new start restarts from stage 0, j=0.
- NUM_FRAMES=3 → 240 words, tw_last on words 80/160/240, single done; with TWIDDLE_SEQ_DIF_EN, stage 0 addresses are 0..15 in order.

Source files
------------

// File: rtl/twiddle_seq_pkg.sv
// Shared constants, tags and address map for the twiddle sequencer.
// TWIDDLE_SEQ_DIF_EN selects DIF address ordering instead of DIT.
package twiddle_seq_pkg;

  localparam int TW_ADDR_W    = 4;
  localparam int TW_STAGES    = 5;
  localparam int TW_PER_STAGE = 16;
  localparam int TW_TAG_W     = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] stage;
    logic [3:0] idx;
    logic       last;
  } tw_tag_t;

  function automatic logic [TW_ADDR_W-1:0] tw_addr(
    input logic [2:0] s,
    input logic [3:0] j
  );
    logic [3:0] m;
`ifdef TWIDDLE_SEQ_DIF_EN
    m = 4'((5'd1 << (3'd4 - s)) - 5'd1);
    return (j & m) << s;
`else
    m = 4'((5'd1 << s) - 5'd1);
    return (j & m) << (3'd4 - s);
`endif
  endfunction

endpackage

// File: rtl/twiddle_seq_if.sv
// Twiddle stream from the sequencer to the PE array.
// Carries the word, its stage/butterfly tag and a valid/ready pair.
interface twiddle_seq_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH*2-1:0] tw_data;
  logic [2:0]              tw_stage;
  logic [3:0]              tw_idx;
  logic                    tw_last;
  logic                    tw_valid;
  logic                    tw_ready;

  modport master (
    output tw_data, tw_stage, tw_idx,
    output tw_last, tw_valid,
    input  tw_ready
  );

  modport slave (
    input  tw_data, tw_stage, tw_idx,
    input  tw_last, tw_valid,
    output tw_ready
  );
endinterface

// File: rtl/twiddle_skid_fifo.sv
// Two-entry skid buffer; the head register drives the output
// directly, so the output is stable while stalled.
module twiddle_skid_fifo #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) head_d = din;
        else               tail_d = din;
      end
      2'b01: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd2) head_d = tail_q;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid = (cnt_q != 2'd0);
  assign dout  = head_q;
  assign count = cnt_q;

endmodule

// File: rtl/twiddle_seq.sv
// Twiddle ROM read sequencer for a 32-point radix-2 FFT.
// Define TWIDDLE_SEQ_DIF_EN for DIF address ordering.
module twiddle_seq
  import twiddle_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_FRAMES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    rom_en,
  output logic [TW_ADDR_W-1:0]    rom_addr,
  input  logic [DATA_WIDTH*2-1:0] rom_data,
  twiddle_seq_if.master           tw
);

  localparam int FW = DATA_WIDTH*2 + TW_TAG_W;

  state_e     state_q, state_d;
  logic [7:0] frame_q, frame_d;
  logic [2:0] s_q, s_d;
  logic [3:0] j_q, j_d;
  logic       inflight_q, inflight_d;
  tw_tag_t    rtag_q, rtag_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic          pop, issue;
  logic          last_word, last_frame;
  logic [1:0]    count;
  logic          fifo_valid;
  logic [FW-1:0] head;
  tw_tag_t       htag;

  assign pop = tw.tw_valid && tw.tw_ready;

  // occupancy + inflight - pop < 2, kept non-negative
  assign issue = (state_q == S_RUN) &&
    (({1'b0, count} + {2'b00, inflight_q})
      < (3'd2 + {2'b00, pop}));

  assign last_word =
    (s_q == 3'(TW_STAGES-1)) &&
    (j_q == 4'(TW_PER_STAGE-1));
  assign last_frame =
    (frame_q == 8'(NUM_FRAMES-1));

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    s_d        = s_q;
    j_d        = j_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    inflight_d = issue;
    rtag_d     = rtag_q;
    if (issue) begin
      rtag_d = '{stage: s_q, idx: j_q,
                 last: last_word};
    end
    unique case (state_q)
      S_IDLE: begin
        frame_d = '0;
        s_d     = '0;
        j_d     = '0;
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (issue) begin
          if (j_q == 4'(TW_PER_STAGE-1)) begin
            j_d = '0;
            if (s_q == 3'(TW_STAGES-1)) begin
              s_d     = '0;
              frame_d = frame_q + 8'd1;
            end else begin
              s_d = s_q + 3'd1;
            end
          end else begin
            j_d = j_q + 4'd1;
          end
          if (last_word && last_frame)
            state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && count == 2'd1 && !inflight_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      s_q        <= '0;
      j_q        <= '0;
      inflight_q <= 1'b0;
      rtag_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      s_q        <= s_d;
      j_q        <= j_d;
      inflight_q <= inflight_d;
      rtag_q     <= rtag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rom_en   = issue;
  assign rom_addr = tw_addr(s_q, j_q);

  twiddle_skid_fifo #(.W(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   ({rom_data, rtag_q}),
    .pop   (pop),
    .valid (fifo_valid),
    .dout  (head),
    .count (count)
  );

  assign htag        = head[TW_TAG_W-1:0];
  assign tw.tw_data  = head[FW-1:TW_TAG_W];
  assign tw.tw_stage = htag.stage;
  assign tw.tw_idx   = htag.idx;
  assign tw.tw_last  = htag.last;
  assign tw.tw_valid = fifo_valid;

endmodule

// File: tb/tb_twiddle_seq.sv
// Directed bench for twiddle_seq with ROM model and scoreboards.
// Honours TWIDDLE_SEQ_DIF_EN in its own address model.
module tb_twiddle_seq;

  localparam int DW  = 16;
  localparam int NF  = 1;
  localparam int WPF = 80;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, rom_en;
  logic [3:0]  rom_addr;
  logic [31:0] rom_data = '0;

  twiddle_seq_if #(.DATA_WIDTH(DW)) tw_if();

  twiddle_seq #(
    .DATA_WIDTH (DW),
    .NUM_FRAMES (NF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .tw       (tw_if)
  );

  always #5 clk = ~clk;

  logic [31:0] rom_tbl [16];
  always @(posedge clk)
    if (rom_en) rom_data <= rom_tbl[rom_addr];

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  s;
    logic [3:0]  j;
    logic        last;
  } exp_t;

  exp_t       exp_q [$];
  logic [3:0] addr_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int words = 0;
  int dones = 0;
  int en_cnt = 0;
  int first_hs = -1;
  int last_hs = -1;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_addr(int s, int j);
`ifdef TWIDDLE_SEQ_DIF_EN
    return 4'((j & ((1 << (4 - s)) - 1)) << s);
`else
    return 4'((j & ((1 << s) - 1)) << (4 - s));
`endif
  endfunction

  task automatic push_run();
    exp_t e;
    logic [3:0] a;
    for (int f = 0; f < NF; f++)
      for (int s = 0; s < 5; s++)
        for (int j = 0; j < 16; j++) begin
          a = exp_addr(s, j);
          addr_q.push_back(a);
          e.d    = rom_tbl[a];
          e.s    = 3'(s);
          e.j    = 4'(j);
          e.last = (s == 4) && (j == 15);
          exp_q.push_back(e);
        end
  endtask

  exp_t cur, prev;
  logic pv = 1'b0;

  always @(negedge clk) begin
    cur.d    = tw_if.tw_data;
    cur.s    = tw_if.tw_stage;
    cur.j    = tw_if.tw_idx;
    cur.last = tw_if.tw_last;
    if (rom_en) begin
      en_cnt++;
      checks++;
      assert (addr_q.size() > 0) else begin
        errors++;
        $error("FAIL addr_extra observed=%0h expected=none",
               rom_addr);
      end
      if (addr_q.size() > 0)
        chk("rom_addr", 64'(rom_addr),
            64'(addr_q.pop_front()));
    end
    if (pv)
      chk("stall_hold", 64'({tw_if.tw_valid, cur}),
          64'({1'b1, prev}));
    if (tw_if.tw_valid && tw_if.tw_ready) begin
      words++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL word_extra observed=%0h expected=none",
               cur);
      end
      if (exp_q.size() > 0)
        chk("word", 64'(cur), 64'(exp_q.pop_front()));
    end
    if (done) begin
      dones++;
      chk("busy_at_done", 64'(busy), 64'(0));
      chk("done_after_last", 64'(cyc),
          64'(last_hs + 1));
    end
    pv   = tw_if.tw_valid && !tw_if.tw_ready && !rst;
    prev = cur;
  end

  task automatic chk_reset();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_rom_en", 64'(rom_en), 64'(0));
    chk("rst_rom_addr", 64'(rom_addr), 64'(0));
    chk("rst_valid", 64'(tw_if.tw_valid), 64'(0));
    chk("rst_data", 64'(tw_if.tw_data), 64'(0));
    chk("rst_stage", 64'(tw_if.tw_stage), 64'(0));
    chk("rst_idx", 64'(tw_if.tw_idx), 64'(0));
    chk("rst_last", 64'(tw_if.tw_last), 64'(0));
  endtask

  task automatic kick();
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk); start_cyc = cyc + 1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'(1));
  endtask

  // mode 0: ready=1, 1: toggle, 2: 10-cycle stall in stage 2
  task automatic run(input int mode, input bit repulse);
    int c, stall, en0, w0;
    bit stalled;
    c = 0; stall = 0; en0 = 0; stalled = 0;
    first_hs = -1; last_hs = -1; dones = 0;
    w0 = words;
    tw_if.tw_ready = 1'b1;
    push_run();
    kick();
    while (dones == 0 && c < 400) begin
      @(posedge clk); #1;
      c++;
      start = repulse && (c % 7 == 3) && (c < 60);
      if (mode == 1) tw_if.tw_ready = ~tw_if.tw_ready;
      if (mode == 2) begin
        if (!stalled && words - w0 >= 40) begin
          stalled = 1'b1; stall = 10; en0 = en_cnt;
        end
        if (stall > 0) begin
          tw_if.tw_ready = 1'b0;
          stall--;
          if (stall == 0) begin
            chk("stall_rom_en_off", 64'(rom_en), 64'(0));
            chk("stall_issue_le2",
                64'((en_cnt - en0) <= 2), 64'(1));
          end
        end else begin
          tw_if.tw_ready = 1'b1;
        end
      end
    end
    start = 1'b0;
    tw_if.tw_ready = 1'b1;
    chk("done_seen", 64'(dones > 0), 64'(1));
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("done_once", 64'(dones), 64'(1));
    chk("words_run", 64'(words - w0), 64'(WPF*NF));
    chk("exp_empty", 64'(exp_q.size()), 64'(0));
    chk("addr_empty", 64'(addr_q.size()), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    int w0, c;
    for (int k = 0; k < 16; k++)
      rom_tbl[k] = {16'h7000 + 16'(k), 16'h0100 * 16'(k)};
    rom_tbl[0] = 32'h0001_0000;
    rom_tbl[8] = 32'h0000_0001;
    rom_tbl[3] = 32'hD4DB_8E40;

    rst = 1'b1; start = 1'b0; tw_if.tw_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset();

    run(0, 1'b0);
    chk("first_latency", 64'(first_hs - start_cyc), 64'(2));
    chk("burst_len", 64'(last_hs - first_hs),
        64'(WPF*NF - 1));

    run(1, 1'b0);
    run(2, 1'b0);
    run(0, 1'b1);

    // reset in the middle of stage 3
    push_run();
    kick();
    w0 = words; c = 0;
    while (words - w0 < 56 && c < 200) begin
      @(posedge clk); c++;
    end
    chk("reach_stage3", 64'(words - w0 >= 56), 64'(1));
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset();
    exp_q.delete();
    addr_q.delete();
    run(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
